// File: rtl/pcr_pkg.sv
// ----------------------------------------------------------------------------
// pcr_pkg: shared definitions for the PC redirect controller.
//   - pc_src select codes consumed by the PC register mux
//   - trap/interrupt FSM state enum
//   - handler vector addresses. The PC module applies these vectors. They are
//     listed here so that every block uses the same values.
// ----------------------------------------------------------------------------
package pcr_pkg;

    localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC = 32'h8000_0008;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_J   = 3'b010;
    localparam logic [2:0] PCSRC_JR  = 3'b011;
    localparam logic [2:0] PCSRC_IRQ = 3'b100;
    localparam logic [2:0] PCSRC_EXC = 3'b101;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_TRAP = 2'd2
    } pcr_state_e;

endpackage

// File: rtl/pcr_target_calc.sv
// ----------------------------------------------------------------------------
// pcr_target_calc: purely combinational redirect target generation.
//   ex_pcplus4 [31:0] in  : PC+4 of the EX-stage branch
//   ex_imm32   [31:0] in  : sign-extended word offset of the branch
//   jt_region  [3:0]  in  : upper PC nibble of the ID instruction (PC+4[31:28])
//   jt_index   [25:0] in  : instr_index field of the ID j/jal
//   con_ba     [31:0] out : branch target, ex_pcplus4 + offset*4 (mod 2^32)
//   jt         [31:0] out : pseudo-direct jump target
// ----------------------------------------------------------------------------
module pcr_target_calc (
    input  logic [31:0] ex_pcplus4,
    input  logic [31:0] ex_imm32,
    input  logic [3:0]  jt_region,
    input  logic [25:0] jt_index,
    output logic [31:0] con_ba,
    output logic [31:0] jt
);

    // The offset bits shifted out at the top are discarded. This produces the
    // required modulo-2^32 wrap for backward branches.
    assign con_ba = ex_pcplus4 + (ex_imm32 << 2);
    assign jt     = {jt_region, jt_index, 2'b00};

endmodule

// File: rtl/pc_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// pc_redirect_ctrl: next-PC select, redirect targets, flush strobes and EPC.
//
// Redirect priority, highest first:
//   taken EX branch > ID illegal-instruction trap > interrupt (TRAP) >
//   ID j/jal > ID jr/jalr.
// A not-taken EX branch still selects PCSRC_BR when nothing else redirects.
// The PC's ALUOut gate then turns that select into PC+4.
//
// Ports:
//   clk, reset (async, active-low)
//   pc_cur            : current PC. Bit KMODE_BIT marks kernel mode.
//   id_valid/id_pcplus4/id_instr/id_jump/id_jr/id_illegal : ID stage decode
//   ex_branch/ex_taken/ex_pcplus4/ex_imm32                 : EX stage branch
//   irq               : level interrupt request. It is taken on a rising edge.
//   pc_src, con_ba, jt: next-PC select and targets
//   flush_if_id, flush_id_ex : pipeline squash strobes
//   epc               : saved resume address
//   irq_ack           : one-cycle pulse in the cycle the interrupt redirects
//
// Build option PCR_REDIRECT_CNT_EN adds redirect_cnt[31:0]. This counter
// counts the cycles that have flush_if_id asserted and wraps at 2^32.
// ----------------------------------------------------------------------------
module pc_redirect_ctrl
    import pcr_pkg::*;
#(
    parameter int KMODE_BIT = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic        id_valid,
    input  logic [31:0] id_pcplus4,
    input  logic [31:0] id_instr,
    input  logic        id_jump,
    input  logic        id_jr,
    input  logic        id_illegal,
    input  logic        ex_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_pcplus4,
    input  logic [31:0] ex_imm32,
    input  logic        irq,
    output logic [2:0]  pc_src,
    output logic [31:0] con_ba,
    output logic [31:0] jt,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] epc,
    output logic        irq_ack
`ifdef PCR_REDIRECT_CNT_EN
    ,
    output logic [31:0] redirect_cnt
`endif
);

    pcr_state_e  state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic        irq_seen_q, irq_seen_d;

    logic kmode;
    logic br_taken;
    logic exc_req;

    // The opcode field is not used by the target math.
    logic unused_opcode;
    assign unused_opcode = ^id_instr[31:26];

    assign kmode    = pc_cur[KMODE_BIT];
    assign br_taken = ex_branch & ex_taken;
    assign exc_req  = id_valid & id_illegal & ~kmode;

    pcr_target_calc u_target_calc (
        .ex_pcplus4 (ex_pcplus4),
        .ex_imm32   (ex_imm32),
        .jt_region  (id_pcplus4[31:28]),
        .jt_index   (id_instr[25:0]),
        .con_ba     (con_ba),
        .jt         (jt)
    );

    always_comb begin
        // NOTE: every output and next-state value gets a default before any
        // branch. Any path that does not assign a value then cannot create a latch.
        pc_src      = PCSRC_SEQ;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        irq_ack     = 1'b0;
        state_d     = state_q;
        epc_d       = epc_q;
        irq_seen_d  = irq;

        if (br_taken) begin
            pc_src      = PCSRC_BR;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (exc_req) begin
            pc_src      = PCSRC_EXC;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            epc_d       = id_pcplus4 - 32'd4;
        end else if (state_q == ST_TRAP) begin
            pc_src      = PCSRC_IRQ;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            irq_ack     = 1'b1;
            epc_d       = pc_cur;
        end else if (id_valid && id_jump) begin
            pc_src      = PCSRC_J;
            flush_if_id = 1'b1;
        end else if (id_valid && id_jr) begin
            pc_src      = PCSRC_JR;
            flush_if_id = 1'b1;
        end else if (ex_branch) begin
            pc_src = PCSRC_BR;
        end

        unique case (state_q)
            ST_RUN: begin
                if (irq && !irq_seen_q && !kmode) state_d = ST_PEND;
            end
            ST_PEND: begin
                // Hold the trap back while a control transfer is in flight.
                // This stops the interrupt from separating that transfer from
                // its redirect.
                if (kmode)                                    state_d = ST_RUN;
                else if (!(ex_branch || id_jump || id_jr))    state_d = ST_TRAP;
            end
            ST_TRAP: begin
                // A higher-priority redirect took this cycle. Retry the
                // interrupt.
                state_d = (br_taken || exc_req) ? ST_PEND : ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // While reset is asserted, the pipeline receives no redirect.
        if (!reset) begin
            pc_src      = PCSRC_SEQ;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
            irq_ack     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together on the edge, and no flop reads a value that
    // another flop has already updated in the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            epc_q      <= '0;
            irq_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            epc_q      <= epc_d;
            irq_seen_q <= irq_seen_d;
        end
    end

    assign epc = epc_q;

`ifdef PCR_REDIRECT_CNT_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q + {31'd0, flush_if_id};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) redirect_cnt_q <= '0;
        else        redirect_cnt_q <= redirect_cnt_d;
    end

    assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_redirect_ctrl: self-checking bench for pc_redirect_ctrl.
// The bench applies directed scenarios and then randomized traffic. A
// behavioural model predicts each cycle's outputs from the redirect rules.
// ----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;
    import pcr_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] pc_cur;
    logic        id_valid;
    logic [31:0] id_pcplus4;
    logic [31:0] id_instr;
    logic        id_jump;
    logic        id_jr;
    logic        id_illegal;
    logic        ex_branch;
    logic        ex_taken;
    logic [31:0] ex_pcplus4;
    logic [31:0] ex_imm32;
    logic        irq;
    logic [2:0]  pc_src;
    logic [31:0] con_ba;
    logic [31:0] jt;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic [31:0] epc;
    logic        irq_ack;
`ifdef PCR_REDIRECT_CNT_EN
    logic [31:0] redirect_cnt;
`endif

    pc_redirect_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .pc_cur      (pc_cur),
        .id_valid    (id_valid),
        .id_pcplus4  (id_pcplus4),
        .id_instr    (id_instr),
        .id_jump     (id_jump),
        .id_jr       (id_jr),
        .id_illegal  (id_illegal),
        .ex_branch   (ex_branch),
        .ex_taken    (ex_taken),
        .ex_pcplus4  (ex_pcplus4),
        .ex_imm32    (ex_imm32),
        .irq         (irq),
        .pc_src      (pc_src),
        .con_ba      (con_ba),
        .jt          (jt),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .epc         (epc),
        .irq_ack     (irq_ack)
`ifdef PCR_REDIRECT_CNT_EN
        ,
        .redirect_cnt(redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The model tracks the interrupt lifecycle as two facts: whether a
    // request is waiting for a clean cycle, and whether this cycle is the
    // trap cycle.
    bit          m_waiting;
    bit          m_trap_now;
    bit          m_irq_prev;
    logic [31:0] m_epc;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_waiting  = 0;
        m_trap_now = 0;
        m_irq_prev = 0;
        m_epc      = 0;
        m_cnt      = 0;
    endtask

    function automatic void predict(output int src, output bit fi, output bit fe, output bit ack);
        bit k = pc_cur[31];
        src = 0; fi = 0; fe = 0; ack = 0;
        if (ex_branch && ex_taken)                  begin src = 1; fi = 1; fe = 1; end
        else if (id_valid && id_illegal && !k)      begin src = 5; fi = 1; fe = 1; end
        else if (m_trap_now)                        begin src = 4; fi = 1; fe = 1; ack = 1; end
        else if (id_valid && id_jump)               begin src = 2; fi = 1; end
        else if (id_valid && id_jr)                 begin src = 3; fi = 1; end
        else if (ex_branch)                         src = 1;
    endfunction

    task automatic model_update();
        int s; bit fi, fe, ack;
        bit k = pc_cur[31];
        predict(s, fi, fe, ack);
        if (s == 5)  m_epc = id_pcplus4 - 4;
        else if (ack) m_epc = pc_cur;
        if (m_trap_now) begin
            m_trap_now = 0;
            m_waiting  = (s == 1 && ex_taken) || s == 5;
        end else if (m_waiting) begin
            if (k) m_waiting = 0;
            else if (!(ex_branch || id_jump || id_jr)) begin
                m_waiting  = 0;
                m_trap_now = 1;
            end
        end else if (irq && !m_irq_prev && !k) begin
            m_waiting = 1;
        end
        m_irq_prev = irq;
        m_cnt = m_cnt + (fi ? 32'd1 : 32'd0);
    endtask

    task automatic compare();
        int s; bit fi, fe, ack;
        predict(s, fi, fe, ack);
        check("pc_src", {29'd0, pc_src}, s);
        check("flush_if_id", {31'd0, flush_if_id}, {31'd0, fi});
        check("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, fe});
        check("irq_ack", {31'd0, irq_ack}, {31'd0, ack});
        check("con_ba", con_ba, ex_pcplus4 + ex_imm32 * 4);
        check("jt", jt, (id_pcplus4 & 32'hF000_0000) | ((id_instr & 32'h03FF_FFFF) * 4));
        check("epc", epc, m_epc);
`ifdef PCR_REDIRECT_CNT_EN
        check("redirect_cnt", redirect_cnt, m_cnt);
`endif
    endtask

    // Inputs change just after a negedge. The checks run #1 later, and the
    // model advances at the posedge.
    task automatic step();
        #1;
        compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        pc_cur = 32'h0000_1000; id_valid = 0; id_pcplus4 = 0; id_instr = 0;
        id_jump = 0; id_jr = 0; id_illegal = 0; ex_branch = 0; ex_taken = 0;
        ex_pcplus4 = 0; ex_imm32 = 0;
    endtask

    initial begin
        $display("vectors irq=%h exc=%h", IRQ_VEC, EXC_VEC);
        clear_inputs();
        irq = 0;
        reset = 0;
        model_reset();
        #1;
        check("rst_pc_src", {29'd0, pc_src}, 32'd0);
        check("rst_epc", epc, 32'd0);
        check("rst_ack", {31'd0, irq_ack}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1;

        // Branch taken, backward offset of -2 words.
        ex_branch = 1; ex_taken = 1; ex_pcplus4 = 32'h10; ex_imm32 = 32'hFFFF_FFFE;
        #1;
        check("br_src", {29'd0, pc_src}, 32'd1);
        check("br_target", con_ba, 32'h0000_0008);
        check("br_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
        step();
        clear_inputs();

        // j with region bits from PC+4.
        id_valid = 1; id_jump = 1; id_pcplus4 = 32'h0040_0004; id_instr = 32'h0810_0003;
        #1;
        check("j_src", {29'd0, pc_src}, 32'd2);
        check("j_target", jt, 32'h0040_000C);
        check("j_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd2);
        step();
        clear_inputs();

        // The interrupt is held back while a not-taken branch is in EX.
        irq = 1; ex_branch = 1; ex_taken = 0; pc_cur = 32'h20;
        #1;
        check("nt_src", {29'd0, pc_src}, 32'd1);
        check("nt_flush", {31'd0, flush_if_id}, 32'd0);
        step();
        ex_branch = 0; pc_cur = 32'h24;
        step();
        pc_cur = 32'h28;
        #1;
        check("trap_src", {29'd0, pc_src}, 32'd4);
        check("trap_ack", {31'd0, irq_ack}, 32'd1);
        step();
        pc_cur = 32'h2C;
        #1;
        check("trap_epc", epc, 32'h28);
        check("post_trap_src", {29'd0, pc_src}, 32'd0);
        step();

        // Kernel mode masks the interrupt edge and the illegal-opcode trap.
        irq = 0; step();
        irq = 1; pc_cur = 32'h8000_0100; id_valid = 1; id_illegal = 1; id_pcplus4 = 32'h8000_0104;
        #1;
        check("kmode_src", {29'd0, pc_src}, 32'd0);
        step();
        pc_cur = 32'h100; id_illegal = 0; step();
        #1;
        check("kmode_no_trap", {29'd0, pc_src}, 32'd0);
        check("kmode_epc", epc, 32'h28);
        step();

        // Illegal opcode in user mode.
        id_valid = 1; id_illegal = 1; id_pcplus4 = 32'h0000_0204;
        step();
        #1;
        check("exc_epc", epc, 32'h0000_0200);
        clear_inputs();
        step();

        // A taken branch collides with the trap cycle.
        irq = 0; step();
        irq = 1; step();
        step();
        ex_branch = 1; ex_taken = 1; ex_pcplus4 = 32'h10; ex_imm32 = 32'hFFFF_FFFE;
        #1;
        check("col_src", {29'd0, pc_src}, 32'd1);
        check("col_ack", {31'd0, irq_ack}, 32'd0);
        step();
        clear_inputs();
        step();
        #1;
        check("col_retrap", {29'd0, pc_src}, 32'd4);
        check("col_retrap_ack", {31'd0, irq_ack}, 32'd1);
        step();

        // Asynchronous reset asserted while a request is waiting.
        irq = 0; step();
        irq = 1; step();
        ex_branch = 1; step();
        #2;
        reset = 0;
        #1;
        model_reset();
        check("async_rst_src", {29'd0, pc_src}, 32'd0);
        check("async_rst_epc", epc, 32'd0);
`ifdef PCR_REDIRECT_CNT_EN
        check("async_rst_cnt", redirect_cnt, 32'd0);
`endif
        @(negedge clk);
        clear_inputs();
        irq = 0;
        reset = 1;
        step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            pc_cur     = {($urandom_range(0, 4) == 0), $urandom() % 32'h8000_0000};
            id_valid   = ($urandom_range(0, 3) != 0);
            id_pcplus4 = $urandom();
            id_instr   = $urandom();
            id_jump    = ($urandom_range(0, 5) == 0);
            id_jr      = ($urandom_range(0, 5) == 0);
            id_illegal = ($urandom_range(0, 9) == 0);
            ex_branch  = ($urandom_range(0, 3) == 0);
            ex_taken   = $urandom_range(0, 1) == 1;
            ex_pcplus4 = $urandom();
            ex_imm32   = $urandom();
            if ($urandom_range(0, 3) == 0) irq = ~irq;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
